// File: rtl/mux_scan_nx1.sv
// Registered N:1 channel multiplexer with valid/ready output, manual select or timed scan.
// Optional macro MUX_PARITY_EN adds a registered even-parity output 'par' alongside Y.
module mux_scan_nx1 #(
    parameter int N     = 16,
    parameter int W     = 8,
    parameter int DWELL = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    A,
    input  logic [SELW-1:0]   sel,
    input  logic              mode,
    input  logic              en,
    input  logic              ready,
    output logic [W-1:0]      Y,
    output logic [SELW-1:0]   ch,
    output logic              valid,
`ifdef MUX_PARITY_EN
    output logic              par,
`endif
    output logic              err,
    output logic              wrap
);

    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SELW-1:0] LAST_CH      = SELW'(N - 1);
    localparam logic [DCW-1:0]  DWELL_RELOAD = DCW'(DWELL - 1);

    logic [W-1:0]    y_q, y_d;
    logic [SELW-1:0] ch_q, ch_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [DCW-1:0]  dwell_q, dwell_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            wrap_q, wrap_d;
    logic            mode_q;
    logic            par_q, par_d;

    logic [SELW-1:0] pick_idx;
    logic [W-1:0]    pick_data;
    logic            pick_hit;
    logic            free, mode_chg, dwell_zero, man_cap, scan_cap, capture;

    // Decode by comparison so an out-of-range sel yields zero data and no hit.
    always_comb begin
        pick_idx  = mode ? ptr_q : sel;
        pick_data = '0;
        pick_hit  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (pick_idx == SELW'(k)) begin
                pick_data = A[k*W +: W];
                pick_hit  = 1'b1;
            end
        end
    end

    assign free       = !valid_q || ready;
    assign mode_chg   = mode ^ mode_q;
    assign dwell_zero = (dwell_q == '0);
    assign man_cap    = !mode && !mode_chg && en && free;
    assign scan_cap   = mode && !mode_chg && dwell_zero && en && free;
    assign capture    = man_cap || scan_cap;

    always_comb begin
        y_d     = y_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        dwell_d = dwell_q;
        valid_d = valid_q;
        err_d   = err_q;
        par_d   = par_q;
        wrap_d  = 1'b0;

        if (mode_chg) begin
            ptr_d   = '0;
            dwell_d = '0;
        end else if (mode) begin
            // A stalled scan holds ptr at dwell==0, so no channel is skipped.
            if (!dwell_zero) begin
                dwell_d = dwell_q - DCW'(1);
            end else if (scan_cap) begin
                dwell_d = DWELL_RELOAD;
                ptr_d   = (ptr_q == LAST_CH) ? '0 : ptr_q + SELW'(1);
                wrap_d  = (ptr_q == LAST_CH);
            end
        end

        if (capture) begin
            y_d     = pick_data;
            ch_d    = pick_idx;
            err_d   = !pick_hit;
            par_d   = ^pick_data;
            valid_d = 1'b1;
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
            dwell_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
            par_q   <= 1'b0;
            // Track the live mode so leaving reset is not seen as a mode change.
            mode_q  <= mode;
        end else begin
            y_q     <= y_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
            dwell_q <= dwell_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
            par_q   <= par_d;
            mode_q  <= mode;
        end
    end

    assign Y     = y_q;
    assign ch    = ch_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign wrap  = wrap_q;
`ifdef MUX_PARITY_EN
    assign par   = par_q;
`else
    logic unused_par;
    assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed bench for mux_scan_nx1: a 16-channel instance for reset/manual/stall/scan
// and a 10-channel instance for out-of-range selects.
module tb_mux_scan_nx1;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] a;
    logic [3:0]   sel;
    logic         mode, en, ready;
    logic [7:0]   y;
    logic [3:0]   ch;
    logic         valid, err, wrap;

    logic [79:0]  a10;
    logic [3:0]   sel10;
    logic         mode10, en10, ready10;
    logic [7:0]   y10;
    logic [3:0]   ch10;
    logic         valid10, err10, wrap10;
`ifdef MUX_PARITY_EN
    logic         par, par10;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int wrap_cnt;

    always #5 clk = ~clk;

    mux_scan_nx1 #(.N(16), .W(8), .DWELL(4)) u_dut (
        .clk(clk), .rst(rst), .A(a), .sel(sel), .mode(mode), .en(en), .ready(ready),
        .Y(y), .ch(ch), .valid(valid),
`ifdef MUX_PARITY_EN
        .par(par),
`endif
        .err(err), .wrap(wrap)
    );

    mux_scan_nx1 #(.N(10), .W(8), .DWELL(4)) u_dut10 (
        .clk(clk), .rst(rst), .A(a10), .sel(sel10), .mode(mode10), .en(en10), .ready(ready10),
        .Y(y10), .ch(ch10), .valid(valid10),
`ifdef MUX_PARITY_EN
        .par(par10),
`endif
        .err(err10), .wrap(wrap10)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; a = '1; sel = '0; mode = 1'b0; en = 1'b1; ready = 1'b1;
        a10 = '0; sel10 = '0; mode10 = 1'b0; en10 = 1'b0; ready10 = 1'b1;

        // Reset with all-ones inputs and capture enabled.
        tick(); tick();
        check("rst_y", 32'(y), 32'h0);
        check("rst_ch", 32'(ch), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        rst = 1'b0;

        for (int k = 0; k < 16; k++) a[k*8 +: 8] = 8'(k + 8'h10);

        // Manual sweep, one capture per cycle.
        for (int k = 0; k < 16; k++) begin
            sel = 4'(k);
            tick();
            check("man_y", 32'(y), 32'(k + 8'h10));
            check("man_ch", 32'(ch), 32'(k));
            check("man_valid", 32'(valid), 32'h1);
        end

        // Stall holds the sample while sel moves.
        sel = 4'd3;
        tick();
        check("stall_cap_y", 32'(y), 32'h13);
        ready = 1'b0; sel = 4'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_y", 32'(y), 32'h13);
            check("stall_ch", 32'(ch), 32'h3);
            check("stall_valid", 32'(valid), 32'h1);
        end
        ready = 1'b1;
        tick();
        check("release_y", 32'(y), 32'h17);
        check("release_ch", 32'(ch), 32'h7);
        en = 1'b0;
        tick();
        check("drain_valid", 32'(valid), 32'h0);
        check("en0_y_hold", 32'(y), 32'h17);

        // Scan: mode-change edge captures nothing, then one capture every 4 edges.
        mode = 1'b1; en = 1'b1;
        tick();
        check("modechg_valid", 32'(valid), 32'h0);
        wrap_cnt = 0;
        for (int c = 0; c < 22; c++) begin
            tick();
            check("scan_valid", 32'(valid), 32'h1);
            check("scan_ch", 32'(ch), 32'(c % 16));
            check("scan_y", 32'(y), 32'((c % 16) + 8'h10));
            check("scan_wrap", 32'(wrap), (c == 15) ? 32'h1 : 32'h0);
            if (wrap) wrap_cnt++;
            if (c == 21) break;
            for (int g = 0; g < 3; g++) begin
                tick();
                check("scan_gap_valid", 32'(valid), 32'h0);
                check("scan_gap_wrap", 32'(wrap), 32'h0);
                if (wrap) wrap_cnt++;
            end
        end
        check("wrap_count", 32'(wrap_cnt), 32'h1);

        // Scan stall at ch=5: the next capture must be ch=6.
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("sstall_ch", 32'(ch), 32'h5);
            check("sstall_y", 32'(y), 32'h15);
            check("sstall_valid", 32'(valid), 32'h1);
        end
        ready = 1'b1;
        tick();
        check("srelease_ch", 32'(ch), 32'h6);
        check("srelease_y", 32'(y), 32'h16);

        // Reset drops a pending unconsumed sample.
        ready = 1'b0;
        tick();
        check("pend_valid", 32'(valid), 32'h1);
        rst = 1'b1;
        tick();
        check("rst_drop_valid", 32'(valid), 32'h0);
        check("rst_drop_y", 32'(y), 32'h0);
        rst = 1'b0; ready = 1'b1; mode = 1'b0; en = 1'b0;

        // Out-of-range manual select on the 10-channel instance.
        for (int k = 0; k < 10; k++) a10[k*8 +: 8] = 8'hA0 + 8'(k);
        a10[2*8 +: 8] = 8'h07;
        en10 = 1'b1; sel10 = 4'd12;
        tick();
        check("oor_err", 32'(err10), 32'h1);
        check("oor_y", 32'(y10), 32'h0);
        check("oor_ch", 32'(ch10), 32'hC);
        check("oor_valid", 32'(valid10), 32'h1);
`ifdef MUX_PARITY_EN
        check("oor_par", 32'(par10), 32'h0);
`endif
        sel10 = 4'd2;
        tick();
        check("inr_err", 32'(err10), 32'h0);
        check("inr_y", 32'(y10), 32'h07);
        check("inr_ch", 32'(ch10), 32'h2);
`ifdef MUX_PARITY_EN
        check("inr_par", 32'(par10), 32'h1);
`endif
        sel10 = 4'd9;
        tick();
        check("last_y", 32'(y10), 32'hA9);
        check("last_err", 32'(err10), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
